fix_serializer: RTL and testbench

FIX_SERIALIZER -- requirements
Module: fix_serializer

---
 rtl/fix_pkg.sv | 25 ++
 rtl/fix_serializer_bin2dec.sv | 26 ++
 rtl/fix_serializer.sv | 229 ++++++++++++++++++++++
 tb/tb_fix_serializer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// fix_pkg: shared constants, widths and FSM state type for the FIX serializer.
// Optional feature macro used by the slice: FIX_SER_CHECKSUM_EN.
package fix_pkg;

  localparam logic [7:0] FIX_DELIM  = 8'h7C;
  localparam logic [7:0] FIX_EQ     = 8'h3D;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  localparam int TAG_W = 32;
  localparam int VAL_W = 256;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_LEAD       = 4'd1,
    ST_TAG        = 4'd2,
    ST_EQ         = 4'd3,
    ST_VALUE      = 4'd4,
    ST_DELIM      = 4'd5,
    ST_WAIT_FIELD = 4'd6,
    ST_CK_TAG     = 4'd7,
    ST_CK_DIG     = 4'd8,
    ST_CK_DELIM   = 4'd9
  } fix_state_e;

endpackage

// File: rtl/fix_serializer_bin2dec.sv
// fix_bin2dec: combinational 8-bit binary to three ASCII decimal digits.
// Ports: bin (0..255) in; hundreds, tens, ones as ASCII characters out.
module fix_bin2dec
  import fix_pkg::*;
(
  input  logic [7:0] bin,
  output logic [7:0] hundreds,
  output logic [7:0] tens,
  output logic [7:0] ones
);

  logic [7:0] h;
  logic [7:0] t;
  logic [7:0] o;

  always_comb begin
    h = bin / 8'd100;
    t = (bin % 8'd100) / 8'd10;
    o = bin % 8'd10;
  end

  assign hundreds = ASCII_ZERO + h;
  assign tens     = ASCII_ZERO + t;
  assign ones     = ASCII_ZERO + o;

endmodule

// File: rtl/fix_serializer.sv
// fix_serializer: turns tag/value fields into a '|'-delimited FIX byte stream.
// Ports: field_* valid/ready input side; data_o/valid_o/ready_i byte output
// with start_of_header_o / end_of_message_o framing. Macro
// FIX_SER_CHECKSUM_EN appends a "10=NNN|" modulo-256 checksum trailer.
module fix_serializer
  import fix_pkg::*;
#(
  parameter int         VAL_BYTES = VAL_W / 8,
  parameter logic [7:0] DELIM     = FIX_DELIM
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   field_valid_i,
  output logic                   field_ready_o,
  input  logic [TAG_W-1:0]       field_tag_i,
  input  logic [1:0]             field_tag_len_i,
  input  logic [8*VAL_BYTES-1:0] field_value_i,
  input  logic [4:0]             field_value_len_i,
  input  logic                   field_last_i,
  output logic [7:0]             data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   start_of_header_o,
  output logic                   end_of_message_o
);

  fix_state_e state;
  fix_state_e state_nx;

  logic [4:0]             idx;
  logic [4:0]             idx_nx;
  logic [TAG_W-1:0]       tag_r;
  logic [1:0]             tag_len_r;
  logic [8*VAL_BYTES-1:0] val_r;
  logic [4:0]             val_len_r;
  logic                   last_r;

  logic       fld_xfer;
  logic       out_xfer;
  logic       tag_done;
  logic       val_done;
  logic       ck_done;
  logic [7:0] cur_byte;

  logic [7:0] tag_bytes [4];
  logic [7:0] val_bytes [32];

  assign field_ready_o = (state == ST_IDLE) ||
                         (state == ST_WAIT_FIELD);
  assign valid_o  = !field_ready_o;
  assign fld_xfer = field_valid_i && field_ready_o;
  assign out_xfer = valid_o && ready_i;

  assign tag_done = (idx == {3'b000, tag_len_r});
  assign val_done = (idx == val_len_r);
  assign ck_done  = (idx == 5'd2);

  // Byte 0 of the tag/value lives in the most significant byte.
  for (genvar g = 0; g < 4; g++) begin : g_tb
    assign tag_bytes[g] = tag_r[8*(3-g) +: 8];
  end

  for (genvar g = 0; g < 32; g++) begin : g_vb
    if (g < VAL_BYTES) begin : g_in
      assign val_bytes[g] = val_r[8*(VAL_BYTES-1-g) +: 8];
    end else begin : g_out
      assign val_bytes[g] = 8'h00;
    end
  end

`ifdef FIX_SER_CHECKSUM_EN
  logic [7:0] cksum;
  logic       sum_en;
  logic [7:0] dig_h;
  logic [7:0] dig_t;
  logic [7:0] dig_o;
  logic [7:0] ck_tag_byte;
  logic [7:0] ck_dig_byte;

  fix_bin2dec u_bin2dec (
    .bin      (cksum),
    .hundreds (dig_h),
    .tens     (dig_t),
    .ones     (dig_o)
  );

  // Only body bytes count: the leading delimiter and trailer are excluded.
  assign sum_en = (state == ST_TAG)   || (state == ST_EQ) ||
                  (state == ST_VALUE) || (state == ST_DELIM);

  always_comb begin
    ck_tag_byte = FIX_EQ;
    ck_dig_byte = dig_o;
    unique case (1'b1)
      idx == 5'd0: begin
        ck_tag_byte = 8'h31;
        ck_dig_byte = dig_h;
      end
      idx == 5'd1: begin
        ck_tag_byte = 8'h30;
        ck_dig_byte = dig_t;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cksum <= 8'h00;
    end else if (fld_xfer && state == ST_IDLE) begin
      cksum <= 8'h00;
    end else if (out_xfer && sum_en) begin
      cksum <= cksum + cur_byte;
    end
  end
`endif

  always_comb begin
    cur_byte = 8'h00;
    case (state)
      ST_LEAD:     cur_byte = DELIM;
      ST_TAG:      cur_byte = tag_bytes[idx[1:0]];
      ST_EQ:       cur_byte = FIX_EQ;
      ST_VALUE:    cur_byte = val_bytes[idx];
      ST_DELIM:    cur_byte = DELIM;
`ifdef FIX_SER_CHECKSUM_EN
      ST_CK_TAG:   cur_byte = ck_tag_byte;
      ST_CK_DIG:   cur_byte = ck_dig_byte;
      ST_CK_DELIM: cur_byte = DELIM;
`endif
      default:     cur_byte = 8'h00;
    endcase
  end

  assign data_o            = cur_byte;
  assign start_of_header_o = (state == ST_LEAD);
`ifdef FIX_SER_CHECKSUM_EN
  assign end_of_message_o  = (state == ST_CK_DELIM);
`else
  assign end_of_message_o  = (state == ST_DELIM) && last_r;
`endif

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      ST_IDLE: begin
        if (fld_xfer) state_nx = ST_LEAD;
      end
      ST_WAIT_FIELD: begin
        if (fld_xfer) state_nx = ST_TAG;
      end
      ST_LEAD: begin
        if (out_xfer) state_nx = ST_TAG;
      end
      ST_TAG: begin
        if (out_xfer) begin
          if (tag_done) state_nx = ST_EQ;
          else          idx_nx   = idx + 5'd1;
        end
      end
      ST_EQ: begin
        if (out_xfer) state_nx = ST_VALUE;
      end
      ST_VALUE: begin
        if (out_xfer) begin
          if (val_done) state_nx = ST_DELIM;
          else          idx_nx   = idx + 5'd1;
        end
      end
      ST_DELIM: begin
        if (out_xfer) begin
          if (!last_r) begin
            state_nx = ST_WAIT_FIELD;
          end else begin
`ifdef FIX_SER_CHECKSUM_EN
            state_nx = ST_CK_TAG;
`else
            state_nx = ST_IDLE;
`endif
          end
        end
      end
`ifdef FIX_SER_CHECKSUM_EN
      ST_CK_TAG: begin
        if (out_xfer) begin
          if (ck_done) state_nx = ST_CK_DIG;
          else         idx_nx   = idx + 5'd1;
        end
      end
      ST_CK_DIG: begin
        if (out_xfer) begin
          if (ck_done) state_nx = ST_CK_DELIM;
          else         idx_nx   = idx + 5'd1;
        end
      end
      ST_CK_DELIM: begin
        if (out_xfer) state_nx = ST_IDLE;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
    // One shared index: every state starts counting from zero.
    if (state_nx != state) idx_nx = 5'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= 5'd0;
      tag_r     <= '0;
      tag_len_r <= 2'd0;
      val_r     <= '0;
      val_len_r <= 5'd0;
      last_r    <= 1'b0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (fld_xfer) begin
        tag_r     <= field_tag_i;
        tag_len_r <= field_tag_len_i;
        val_r     <= field_value_i;
        val_len_r <= field_value_len_i;
        last_r    <= field_last_i;
      end
    end
  end

endmodule

// File: tb/tb_fix_serializer.sv
// tb_fix_serializer: directed checks of the FIX serializer byte stream.
// Expected streams adapt to whether FIX_SER_CHECKSUM_EN is defined.
module tb_fix_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         field_valid_i = 1'b0;
  logic         field_ready_o;
  logic [31:0]  field_tag_i = '0;
  logic [1:0]   field_tag_len_i = '0;
  logic [255:0] field_value_i = '0;
  logic [4:0]   field_value_len_i = '0;
  logic         field_last_i = 1'b0;
  logic [7:0]   data_o;
  logic         valid_o;
  logic         ready_i = 1'b1;
  logic         start_of_header_o;
  logic         end_of_message_o;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx_d[$];
  logic       rx_s[$];
  logic       rx_e[$];
  int         eom_cnt = 0;

  fix_serializer dut (
    .clk               (clk),
    .rst               (rst),
    .field_valid_i     (field_valid_i),
    .field_ready_o     (field_ready_o),
    .field_tag_i       (field_tag_i),
    .field_tag_len_i   (field_tag_len_i),
    .field_value_i     (field_value_i),
    .field_value_len_i (field_value_len_i),
    .field_last_i      (field_last_i),
    .data_o            (data_o),
    .valid_o           (valid_o),
    .ready_i           (ready_i),
    .start_of_header_o (start_of_header_o),
    .end_of_message_o  (end_of_message_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && valid_o && ready_i) begin
      rx_d.push_back(data_o);
      rx_s.push_back(start_of_header_o);
      rx_e.push_back(end_of_message_o);
      if (end_of_message_o) eom_cnt++;
    end
  end

  function automatic logic [31:0] mk_tag(input string s);
    logic [31:0] r = '0;
    for (int i = 0; i < s.len(); i++)
      r = r | (32'(s[i]) << (24 - 8 * i));
    return r;
  endfunction

  function automatic logic [255:0] mk_val(input string s);
    logic [255:0] r = '0;
    for (int i = 0; i < s.len(); i++)
      r = r | (256'(s[i]) << (248 - 8 * i));
    return r;
  endfunction

  task automatic clear_rx();
    rx_d.delete();
    rx_s.delete();
    rx_e.delete();
    eom_cnt = 0;
  endtask

  task automatic send_field(input string tg, input string vl,
                            input logic lst, input string nm);
    int n = 0;
    @(posedge clk);
    #1;
    field_tag_i       = mk_tag(tg);
    field_tag_len_i   = 2'(tg.len() - 1);
    field_value_i     = mk_val(vl);
    field_value_len_i = 5'(vl.len() - 1);
    field_last_i      = lst;
    field_valid_i     = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!field_ready_o && n < 200);
    checks++;
    if (!field_ready_o) begin
      errors++;
      $display("FAIL %s field_ready got=0 want=1 (timeout)", nm);
    end
    @(posedge clk);
    #1;
    field_valid_i = 1'b0;
  endtask

  task automatic wait_eom(input string nm);
    int n = 0;
    while (eom_cnt == 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (eom_cnt == 0) begin
      errors++;
      $display("FAIL %s eom got=none want=seen (timeout)", nm);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({valid_o, start_of_header_o, end_of_message_o, data_o} !== 11'h0) begin
      errors++;
      $display("FAIL reset_out got v=%b s=%b e=%b d=%h want 0 0 0 00",
               valid_o, start_of_header_o, end_of_message_o, data_o);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (field_ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got fr=%b v=%b want fr=1 v=0",
               field_ready_o, valid_o);
    end
  endtask

  task automatic test_single(input string tg, input string vl,
                             input string e, input string nm);
    clear_rx();
    send_field(tg, vl, 1'b1, nm);
    wait_eom(nm);
    checks++;
    if (rx_d.size() != e.len()) begin
      errors++;
      $display("FAIL %s len got=%0d want=%0d", nm, rx_d.size(), e.len());
    end
    for (int i = 0; i < e.len(); i++) begin
      checks++;
      if (i >= rx_d.size()) begin
        errors++;
        $display("FAIL %s byte[%0d] got=none want=%h", nm, i, e[i]);
      end else if ({rx_d[i], rx_s[i], rx_e[i]} !==
                   {e[i], i == 0, i == e.len() - 1}) begin
        errors++;
        $display("FAIL %s byte[%0d] got=%h s=%b e=%b want=%h s=%b e=%b",
                 nm, i, rx_d[i], rx_s[i], rx_e[i],
                 e[i], i == 0, i == e.len() - 1);
      end
    end
    checks++;
    if (field_ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s idle got fr=%b v=%b want fr=1 v=0",
               nm, field_ready_o, valid_o);
    end
  endtask

  task automatic test_back_to_back();
    string e;
    int    n = 0;
`ifdef FIX_SER_CHECKSUM_EN
    e = "|8=FIX.4.2|9=178|10=044|";
`else
    e = "|8=FIX.4.2|9=178|";
`endif
    clear_rx();
    send_field("8", "FIX.4.2", 1'b0, "b2b_f1");
    do begin
      @(negedge clk);
      if (!field_ready_o) n++;
    end while (!field_ready_o && n < 100);
    checks++;
    if (n != 11 || rx_d.size() != 11) begin
      errors++;
      $display("FAIL b2b_ready_low got cycles=%0d bytes=%0d want 11 11",
               n, rx_d.size());
    end
    send_field("9", "178", 1'b1, "b2b_f2");
    wait_eom("b2b");
    checks++;
    if (rx_d.size() != e.len()) begin
      errors++;
      $display("FAIL b2b len got=%0d want=%0d", rx_d.size(), e.len());
    end
    for (int i = 0; i < e.len(); i++) begin
      checks++;
      if (i >= rx_d.size()) begin
        errors++;
        $display("FAIL b2b byte[%0d] got=none want=%h", i, e[i]);
      end else if ({rx_d[i], rx_s[i], rx_e[i]} !==
                   {e[i], i == 0, i == e.len() - 1}) begin
        errors++;
        $display("FAIL b2b byte[%0d] got=%h s=%b e=%b want=%h s=%b e=%b",
                 i, rx_d[i], rx_s[i], rx_e[i],
                 e[i], i == 0, i == e.len() - 1);
      end
    end
  endtask

  task automatic test_backpressure();
    string      v;
    string      body;
    string      e;
    logic [7:0] sum = 8'h00;
    logic [7:0] held;
    v    = "abcdefghijklmnopqrstuvwxyz012345";
    body = {"58=", v, "|"};
    for (int i = 0; i < body.len(); i++) sum = sum + body[i];
`ifdef FIX_SER_CHECKSUM_EN
    e = {"|", body, "10=", $sformatf("%03d", sum), "|"};
`else
    e = {"|", body};
`endif
    clear_rx();
    send_field("58", v, 1'b1, "bp");
    repeat (8) @(posedge clk);
    #1 ready_i = 1'b0;
    @(negedge clk);
    held = data_o;
    checks++;
    if (held !== e[8] || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_stall_byte got=%h v=%b want=%h v=1",
               held, valid_o, e[8]);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({data_o, valid_o, start_of_header_o, end_of_message_o} !==
          {held, 3'b100}) begin
        errors++;
        $display("FAIL bp_hold got=%h v=%b s=%b e=%b want=%h 1 0 0",
                 data_o, valid_o, start_of_header_o, end_of_message_o,
                 held);
      end
    end
    @(posedge clk);
    #1 ready_i = 1'b1;
    wait_eom("bp");
    checks++;
    if (rx_d.size() != e.len()) begin
      errors++;
      $display("FAIL bp len got=%0d want=%0d", rx_d.size(), e.len());
    end
    for (int i = 0; i < e.len(); i++) begin
      checks++;
      if (i >= rx_d.size()) begin
        errors++;
        $display("FAIL bp byte[%0d] got=none want=%h", i, e[i]);
      end else if ({rx_d[i], rx_s[i], rx_e[i]} !==
                   {e[i], i == 0, i == e.len() - 1}) begin
        errors++;
        $display("FAIL bp byte[%0d] got=%h s=%b e=%b want=%h s=%b e=%b",
                 i, rx_d[i], rx_s[i], rx_e[i],
                 e[i], i == 0, i == e.len() - 1);
      end
    end
  endtask

  task automatic test_reset_mid();
    string e;
`ifdef FIX_SER_CHECKSUM_EN
    e = "|8=A|10=050|";
`else
    e = "|8=A|";
`endif
    clear_rx();
    send_field("8", "A", 1'b1, "rm_f1");
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({valid_o, start_of_header_o, end_of_message_o, data_o} !== 11'h0 ||
        field_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rm_async got v=%b s=%b e=%b d=%h fr=%b want 0 0 0 00 1",
               valid_o, start_of_header_o, end_of_message_o, data_o,
               field_ready_o);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    clear_rx();
    test_single("8", "A", e, "rm_next");
  endtask

  initial begin
    string e1;
    string e2;
`ifdef FIX_SER_CHECKSUM_EN
    e1 = "|8=A|10=050|";
    e2 = "|35=8|10=089|";
`else
    e1 = "|8=A|";
    e2 = "|35=8|";
`endif
    test_reset();
    test_single("8", "A", e1, "single");
    test_single("35", "8", e2, "tag35");
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
